// File: rtl/vx_dram_throttle_pkg.sv
// Shared defaults and helpers for the DRAM read throttle.
// The widths here are only fallbacks; integrators pass the platform widths at instantiation.
package vx_dram_throttle_pkg;

    localparam int DEF_DATA_WIDTH  = 512;
    localparam int DEF_ADDR_WIDTH  = 26;
    localparam int DEF_TAG_WIDTH   = 8;
    localparam int DEF_MAX_PENDING = 8;

    // Counter must hold the value MAX_PENDING itself, hence the +1.
    function automatic int pending_width(input int max_pending);
        return $clog2(max_pending + 1);
    endfunction

endpackage

// File: rtl/vx_dram_throttle_queue.sv
// First-word fall-through FIFO with an arbitrary (non power-of-two) depth.
// Write-to-read latency one cycle; push while full is accepted only together with a pop.
module vx_generic_queue #(
    parameter int DATAW = 8,
    parameter int SIZE  = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [DATAW-1:0] data_in,
    output logic [DATAW-1:0] data_out,
    output logic             empty,
    output logic             full
);

    localparam int AW = (SIZE > 1) ? $clog2(SIZE) : 1;
    localparam int CW = $clog2(SIZE + 1);

    logic [DATAW-1:0] mem [SIZE];
    logic [AW-1:0]    rd_ptr;
    logic [AW-1:0]    wr_ptr;
    logic [CW-1:0]    count;
    logic             do_push;
    logic             do_pop;

    assign empty    = (count == '0);
    assign full     = (count == CW'(SIZE));
    assign do_pop   = pop && !empty;
    assign do_push  = push && (!full || do_pop);
    assign data_out = mem[rd_ptr];

    function automatic logic [AW-1:0] ptr_next(input logic [AW-1:0] p);
        return (p == AW'(SIZE - 1)) ? '0 : p + AW'(1);
    endfunction

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= ptr_next(wr_ptr);
            if (do_pop)  rd_ptr <= ptr_next(rd_ptr);
            if (do_push && !do_pop)      count <= count + CW'(1);
            else if (do_pop && !do_push) count <= count - CW'(1);
        end
    end

    // Storage needs no reset: pointers alone define which entries are live.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= data_in;
    end

endmodule

// File: rtl/vx_dram_throttle.sv
// Caps outstanding DRAM reads at MAX_PENDING; requests pass through a one-entry register (1 cycle),
// responses through a fall-through FIFO. Backpressure: reads stall at the credit limit, writes never do.
module vx_dram_throttle
    import vx_dram_throttle_pkg::*;
#(
    parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH  = DEF_ADDR_WIDTH,
    parameter int TAG_WIDTH   = DEF_TAG_WIDTH,
    parameter int MAX_PENDING = DEF_MAX_PENDING,
    localparam int BYTEEN     = DATA_WIDTH / 8,
    localparam int PW         = pending_width(MAX_PENDING)
) (
    input  logic                  clk,
    input  logic                  reset,

    input  logic                  core_req_valid,
    input  logic                  core_req_rw,
    input  logic [BYTEEN-1:0]     core_req_byteen,
    input  logic [ADDR_WIDTH-1:0] core_req_addr,
    input  logic [DATA_WIDTH-1:0] core_req_data,
    input  logic [TAG_WIDTH-1:0]  core_req_tag,
    output logic                  core_req_ready,

    output logic                  mem_req_valid,
    output logic                  mem_req_rw,
    output logic [BYTEEN-1:0]     mem_req_byteen,
    output logic [ADDR_WIDTH-1:0] mem_req_addr,
    output logic [DATA_WIDTH-1:0] mem_req_data,
    output logic [TAG_WIDTH-1:0]  mem_req_tag,
    input  logic                  mem_req_ready,

    input  logic                  mem_rsp_valid,
    input  logic [DATA_WIDTH-1:0] mem_rsp_data,
    input  logic [TAG_WIDTH-1:0]  mem_rsp_tag,
    output logic                  mem_rsp_ready,

    output logic                  core_rsp_valid,
    output logic [DATA_WIDTH-1:0] core_rsp_data,
    output logic [TAG_WIDTH-1:0]  core_rsp_tag,
    input  logic                  core_rsp_ready,

    output logic [PW-1:0]         pending,
    output logic                  busy
);

    logic req_fire;
    logic rd_fire;
    logic rsp_fire;
    logic rsp_push;
    logic fifo_empty;
    logic fifo_full;

    // Reset gates ready so nothing is accepted while the block is held in reset.
    assign core_req_ready = reset && (!mem_req_valid || mem_req_ready)
                          && (core_req_rw || (pending < PW'(MAX_PENDING)));

    assign req_fire = core_req_valid && core_req_ready;
    assign rd_fire  = req_fire && !core_req_rw;
    assign rsp_fire = core_rsp_valid && core_rsp_ready;
    assign rsp_push = mem_rsp_valid && mem_rsp_ready;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mem_req_valid <= 1'b0;
        end else if (req_fire) begin
            mem_req_valid <= 1'b1;
        end else if (mem_req_ready) begin
            mem_req_valid <= 1'b0;
        end
    end

    // Payload loads only on accept, so it holds steady while the controller stalls.
    always_ff @(posedge clk) begin
        if (req_fire) begin
            mem_req_rw     <= core_req_rw;
            mem_req_byteen <= core_req_byteen;
            mem_req_addr   <= core_req_addr;
            mem_req_data   <= core_req_data;
            mem_req_tag    <= core_req_tag;
        end
    end

    // A credit is returned only when the response leaves toward the core.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pending <= '0;
        end else if (rd_fire && !rsp_fire) begin
            pending <= pending + PW'(1);
        end else if (rsp_fire && !rd_fire && (pending != '0)) begin
            pending <= pending - PW'(1);
        end
    end

    assign busy = (pending != '0) || mem_req_valid;

    vx_generic_queue #(
        .DATAW (DATA_WIDTH + TAG_WIDTH),
        .SIZE  (MAX_PENDING)
    ) rsp_queue (
        .clk      (clk),
        .reset    (reset),
        .push     (rsp_push),
        .pop      (rsp_fire),
        .data_in  ({mem_rsp_data, mem_rsp_tag}),
        .data_out ({core_rsp_data, core_rsp_tag}),
        .empty    (fifo_empty),
        .full     (fifo_full)
    );

    assign mem_rsp_ready  = !fifo_full;
    assign core_rsp_valid = !fifo_empty;

    unexpected_rsp: assert property (@(posedge clk) disable iff (!reset)
        !(mem_rsp_valid && (pending == '0)))
        else $error("mem_rsp_valid with no read outstanding");

endmodule

// File: tb/tb_vx_dram_throttle.sv
module tb_vx_dram_throttle;

    localparam int DW = 64;
    localparam int AW = 26;
    localparam int TW = 8;
    localparam int MP = 8;
    localparam int BE = DW / 8;
    localparam int PW = 4;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          core_req_valid = 1'b0, core_req_rw = 1'b0;
    logic [BE-1:0] core_req_byteen = '0;
    logic [AW-1:0] core_req_addr = '0;
    logic [DW-1:0] core_req_data = '0;
    logic [TW-1:0] core_req_tag = '0;
    logic          core_req_ready;
    logic          mem_req_valid, mem_req_rw;
    logic [BE-1:0] mem_req_byteen;
    logic [AW-1:0] mem_req_addr;
    logic [DW-1:0] mem_req_data;
    logic [TW-1:0] mem_req_tag;
    logic          mem_req_ready = 1'b0;
    logic          mem_rsp_valid = 1'b0;
    logic [DW-1:0] mem_rsp_data = '0;
    logic [TW-1:0] mem_rsp_tag = '0;
    logic          mem_rsp_ready;
    logic          core_rsp_valid;
    logic [DW-1:0] core_rsp_data;
    logic [TW-1:0] core_rsp_tag;
    logic          core_rsp_ready = 1'b0;
    logic [PW-1:0] pending;
    logic          busy;

    int vectors = 0;
    int miscompares = 0;

    vx_dram_throttle #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .TAG_WIDTH(TW), .MAX_PENDING(MP)) dut (
        .clk(clk), .reset(reset),
        .core_req_valid(core_req_valid), .core_req_rw(core_req_rw), .core_req_byteen(core_req_byteen),
        .core_req_addr(core_req_addr), .core_req_data(core_req_data), .core_req_tag(core_req_tag),
        .core_req_ready(core_req_ready),
        .mem_req_valid(mem_req_valid), .mem_req_rw(mem_req_rw), .mem_req_byteen(mem_req_byteen),
        .mem_req_addr(mem_req_addr), .mem_req_data(mem_req_data), .mem_req_tag(mem_req_tag),
        .mem_req_ready(mem_req_ready),
        .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data), .mem_rsp_tag(mem_rsp_tag),
        .mem_rsp_ready(mem_rsp_ready),
        .core_rsp_valid(core_rsp_valid), .core_rsp_data(core_rsp_data), .core_rsp_tag(core_rsp_tag),
        .core_rsp_ready(core_rsp_ready),
        .pending(pending), .busy(busy)
    );

    always #5 clk = ~clk;

    // Payload fields are derived from the address so every field can be cross-checked.
    function automatic logic [DW-1:0] data_of(input logic [AW-1:0] a);
        return {6'h2D, a, ~a, 6'h11};
    endfunction
    function automatic logic [TW-1:0] tag_of(input logic [AW-1:0] a);
        return a[7:0] ^ 8'h5A;
    endfunction
    function automatic logic [BE-1:0] be_of(input logic [AW-1:0] a);
        return a[7:0] ^ 8'hC3;
    endfunction

    task automatic cmp(input string nm, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic drive(input logic vld, input logic rw, input logic [AW-1:0] addr, input logic mrdy,
                         input logic rspv, input logic [TW-1:0] rtag, input logic crrdy);
        core_req_valid  = vld;
        core_req_rw     = rw;
        core_req_addr   = addr;
        core_req_byteen = be_of(addr);
        core_req_data   = data_of(addr);
        core_req_tag    = tag_of(addr);
        mem_req_ready   = mrdy;
        mem_rsp_valid   = rspv;
        mem_rsp_tag     = rtag;
        mem_rsp_data    = data_of(AW'(rtag));
        core_rsp_ready  = crrdy;
    endtask

    // ---------------- reference model ----------------
    bit            m_hv;
    logic          m_rw;
    logic [AW-1:0] m_addr;
    logic [BE-1:0] m_be;
    logic [DW-1:0] m_dat;
    logic [TW-1:0] m_tag;
    int            m_pend;
    int            owed;
    logic [DW+TW-1:0] m_q[$];

    task automatic model_reset();
        m_hv = 0; m_pend = 0; owed = 0; m_q.delete();
    endtask

    task automatic model_cycle();
        bit e_rdy, fire, mfire, push, pop;
        @(negedge clk);
        e_rdy = (!m_hv || mem_req_ready) && (core_req_rw || m_pend < MP);
        cmp("core_req_ready", 64'(core_req_ready), 64'(e_rdy));
        cmp("mem_req_valid", 64'(mem_req_valid), 64'(m_hv));
        if (m_hv) begin
            cmp("mem_req_rw", 64'(mem_req_rw), 64'(m_rw));
            cmp("mem_req_addr", 64'(mem_req_addr), 64'(m_addr));
            cmp("mem_req_byteen", 64'(mem_req_byteen), 64'(m_be));
            cmp("mem_req_data", mem_req_data, m_dat);
            cmp("mem_req_tag", 64'(mem_req_tag), 64'(m_tag));
        end
        cmp("mem_rsp_ready", 64'(mem_rsp_ready), 64'(m_q.size() < MP));
        cmp("core_rsp_valid", 64'(core_rsp_valid), 64'(m_q.size() > 0));
        if (m_q.size() > 0) begin
            cmp("core_rsp_data", core_rsp_data, m_q[0][DW+TW-1:TW]);
            cmp("core_rsp_tag", 64'(core_rsp_tag), 64'(m_q[0][TW-1:0]));
        end
        cmp("pending", 64'(pending), 64'(m_pend));
        cmp("busy", 64'(busy), 64'((m_pend != 0) || m_hv));

        fire  = core_req_valid && e_rdy;
        mfire = m_hv && mem_req_ready;
        push  = mem_rsp_valid && (m_q.size() < MP);
        pop   = (m_q.size() > 0) && core_rsp_ready;
        if (fire && !core_req_rw && !pop) m_pend++;
        else if (pop && !(fire && !core_req_rw) && m_pend > 0) m_pend--;
        if (fire && !core_req_rw) owed++;
        if (push) owed--;
        if (pop) void'(m_q.pop_front());
        if (push) m_q.push_back({mem_rsp_data, mem_rsp_tag});
        if (fire) begin
            m_hv = 1; m_rw = core_req_rw; m_addr = core_req_addr;
            m_be = core_req_byteen; m_dat = core_req_data; m_tag = core_req_tag;
        end else if (mfire) begin
            m_hv = 0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        cmp({tag, ".mem_req_valid"}, 64'(mem_req_valid), 64'(0));
        cmp({tag, ".core_rsp_valid"}, 64'(core_rsp_valid), 64'(0));
        cmp({tag, ".pending"}, 64'(pending), 64'(0));
        cmp({tag, ".busy"}, 64'(busy), 64'(0));
        cmp({tag, ".mem_rsp_ready"}, 64'(mem_rsp_ready), 64'(1));
        cmp({tag, ".core_req_ready"}, 64'(core_req_ready), 64'(0));
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic vld, rw; logic [AW-1:0] addr; logic mrdy, rspv; logic [TW-1:0] rtag; logic crrdy;
        logic e_crdy, e_mvld; logic [AW-1:0] e_maddr; logic e_mrw; int e_pend;
        logic e_rspv; logic [TW-1:0] e_rtag;
    } vec_t;

    vec_t tbl[24];

    function automatic vec_t mk(input logic vld, input logic rw, input logic [AW-1:0] addr,
                                input logic mrdy, input logic rspv, input logic [TW-1:0] rtag,
                                input logic crrdy, input logic e_crdy, input logic e_mvld,
                                input logic [AW-1:0] e_maddr, input logic e_mrw, input int e_pend,
                                input logic e_rspv, input logic [TW-1:0] e_rtag);
        vec_t v;
        v.vld = vld; v.rw = rw; v.addr = addr; v.mrdy = mrdy; v.rspv = rspv; v.rtag = rtag;
        v.crrdy = crrdy; v.e_crdy = e_crdy; v.e_mvld = e_mvld; v.e_maddr = e_maddr; v.e_mrw = e_mrw;
        v.e_pend = e_pend; v.e_rspv = e_rspv; v.e_rtag = e_rtag;
        return v;
    endfunction

    initial begin
        // 8 back-to-back reads fill the credits; the 9th is refused.
        tbl[0] = mk(1, 0, 0, 1, 0, 0, 0,  1, 0, 0, 0, 0, 0, 0);
        for (int k = 1; k < 8; k++)
            tbl[k] = mk(1, 0, AW'(k), 1, 0, 0, 0,  1, 1, AW'(k - 1), 0, k, 0, 0);
        tbl[8]  = mk(1, 0, 8, 1, 0, 0, 0,      0, 1, 7, 0, 8, 0, 0);
        // A write passes at full credit and shows up unchanged, held through one stall.
        tbl[9]  = mk(1, 1, 'h100, 1, 0, 0, 0,  1, 0, 0, 0, 8, 0, 0);
        tbl[10] = mk(0, 0, 0, 0, 0, 0, 0,      0, 1, 'h100, 1, 8, 0, 0);
        tbl[11] = mk(0, 0, 0, 1, 0, 0, 0,      0, 1, 'h100, 1, 8, 0, 0);
        // Responses 3,1,2 come out in order, one cycle after each arrives.
        tbl[12] = mk(0, 0, 0, 1, 1, 3, 1,      0, 0, 0, 0, 8, 0, 0);
        tbl[13] = mk(0, 0, 0, 1, 1, 1, 1,      0, 0, 0, 0, 8, 1, 3);
        tbl[14] = mk(0, 0, 0, 1, 1, 2, 1,      1, 0, 0, 0, 7, 1, 1);
        tbl[15] = mk(0, 0, 0, 1, 0, 0, 1,      1, 0, 0, 0, 6, 1, 2);
        tbl[16] = mk(0, 0, 0, 1, 1, 9, 1,      1, 0, 0, 0, 5, 0, 0);
        // Read accept and response pop together at pending=5.
        tbl[17] = mk(1, 0, 'h2A, 0, 0, 0, 1,   1, 0, 0, 0, 5, 1, 9);
        // Controller stalls 4 cycles on 0x2A, then takes it exactly once.
        for (int k = 18; k < 22; k++)
            tbl[k] = mk(1, 0, 'h2B, 0, 0, 0, 1, 0, 1, 'h2A, 0, 5, 0, 0);
        tbl[22] = mk(0, 0, 0, 1, 0, 0, 1,      1, 1, 'h2A, 0, 5, 0, 0);
        tbl[23] = mk(0, 0, 0, 1, 0, 0, 1,      1, 0, 0, 0, 5, 0, 0);
    end

    initial begin
        #1;
        check_reset_outputs("reset_idle");
        @(posedge clk); @(posedge clk); #1;
        reset = 1'b1;

        foreach (tbl[i]) begin
            drive(tbl[i].vld, tbl[i].rw, tbl[i].addr, tbl[i].mrdy, tbl[i].rspv, tbl[i].rtag, tbl[i].crrdy);
            @(negedge clk);
            cmp($sformatf("t%0d.core_req_ready", i), 64'(core_req_ready), 64'(tbl[i].e_crdy));
            cmp($sformatf("t%0d.mem_req_valid", i), 64'(mem_req_valid), 64'(tbl[i].e_mvld));
            if (tbl[i].e_mvld) begin
                cmp($sformatf("t%0d.mem_req_addr", i), 64'(mem_req_addr), 64'(tbl[i].e_maddr));
                cmp($sformatf("t%0d.mem_req_rw", i), 64'(mem_req_rw), 64'(tbl[i].e_mrw));
                cmp($sformatf("t%0d.mem_req_byteen", i), 64'(mem_req_byteen), 64'(be_of(tbl[i].e_maddr)));
                cmp($sformatf("t%0d.mem_req_data", i), mem_req_data, data_of(tbl[i].e_maddr));
                cmp($sformatf("t%0d.mem_req_tag", i), 64'(mem_req_tag), 64'(tag_of(tbl[i].e_maddr)));
            end
            cmp($sformatf("t%0d.pending", i), 64'(pending), 64'(tbl[i].e_pend));
            cmp($sformatf("t%0d.busy", i), 64'(busy), 64'((tbl[i].e_pend != 0) || tbl[i].e_mvld));
            cmp($sformatf("t%0d.mem_rsp_ready", i), 64'(mem_rsp_ready), 64'(1));
            cmp($sformatf("t%0d.core_rsp_valid", i), 64'(core_rsp_valid), 64'(tbl[i].e_rspv));
            if (tbl[i].e_rspv) begin
                cmp($sformatf("t%0d.core_rsp_tag", i), 64'(core_rsp_tag), 64'(tbl[i].e_rtag));
                cmp($sformatf("t%0d.core_rsp_data", i), core_rsp_data, data_of(AW'(tbl[i].e_rtag)));
            end
            @(posedge clk); #1;
        end

        // Fresh start, then build pending=4 with 2 queued responses and a held request.
        drive(0, 0, 0, 0, 0, 0, 0);
        reset = 1'b0; #2; reset = 1'b1;
        model_reset();
        for (int k = 0; k < 4; k++) begin
            drive(1, 0, AW'('h40 + k), 1, 0, 0, 0);
            model_cycle();
        end
        drive(1, 1, 'h77, 0, 1, 8'h11, 0);
        model_cycle();
        drive(0, 0, 0, 0, 1, 8'h12, 0);
        model_cycle();
        drive(0, 0, 0, 0, 0, 0, 0);
        model_cycle();
        cmp("pre_reset.pending", 64'(pending), 64'(4));
        cmp("pre_reset.core_rsp_valid", 64'(core_rsp_valid), 64'(1));
        #2;
        reset = 1'b0;
        #1;
        check_reset_outputs("async_reset");
        #2;
        reset = 1'b1;
        model_reset();
        for (int k = 0; k < 4; k++) begin
            drive(0, 0, 0, 1, 0, 0, 1);
            model_cycle();
        end

        // Randomized traffic against the model, with phases of varying core backpressure.
        for (int c = 0; c < 1600; c++) begin
            int crdy_pct;
            crdy_pct = ((c / 200) % 2 == 0) ? 80 : 15;
            drive($urandom_range(0, 1) == 1, $urandom_range(0, 3) == 0, AW'($urandom),
                  $urandom_range(0, 3) != 0,
                  (owed > 0) && ($urandom_range(0, 1) == 1), TW'($urandom),
                  $urandom_range(0, 99) < crdy_pct);
            model_cycle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/vx_dram_throttle.md
VX_DRAM_THROTTLE -- requirements
Module: VX_dram_throttle

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 512, DRAM line width in bits.
REQ-002 SHALL have parameter ADDR_WIDTH, default 26, DRAM line address width.
REQ-003 SHALL have parameter TAG_WIDTH, default 8, DRAM tag width.
REQ-004 SHALL have parameter MAX_PENDING, default 8, maximum outstanding reads; legal range 2..64.
REQ-005 SHALL have the ports below; BYTEEN = DATA_WIDTH/8 and PW = clog2(MAX_PENDING+1).
- clk  in  1  sole clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- core_req_valid/rw/byteen/addr/data/tag  in  1/1/BYTEEN/ADDR_WIDTH/DATA_WIDTH/TAG_WIDTH  upstream DRAM request from Vortex.
- core_req_ready  out  1  request accepted.
- mem_req_valid/rw/byteen/addr/data/tag  out  same widths  request to DRAM controller.
- mem_req_ready  in  1  controller accepts.
- mem_rsp_valid/data/tag  in  1/DATA_WIDTH/TAG_WIDTH  controller read response.
- mem_rsp_ready  out  1  response accepted.
- core_rsp_valid/data/tag  out  1/DATA_WIDTH/TAG_WIDTH  response to Vortex.
- core_rsp_ready  in  1  Vortex accepts.
- pending  out  PW  outstanding read count.
- busy  out  1  any read outstanding or request held.

Function
REQ-006 A transfer on any channel SHALL occur only on a rising edge with valid && ready high.
REQ-007 The request path SHALL be a one-entry output register: an accepted request SHALL appear on mem_req_* the next cycle, with all fields unchanged.
REQ-008 mem_req_* SHALL remain stable while mem_req_valid && !mem_req_ready.
REQ-009 core_req_ready SHALL be (!mem_req_valid || mem_req_ready) && (core_req_rw || pending < MAX_PENDING); combinational, with no dependency on core_req_valid.
REQ-010 Writes (rw=1) SHALL consume no credit and produce no response.
REQ-011 pending SHALL increment on every accepted core read and decrement on every core_rsp transfer; if both occur in the same cycle it SHALL stay unchanged.
REQ-012 pending SHALL never exceed MAX_PENDING nor underflow below 0.
REQ-013 Responses SHALL enter a FIFO of depth MAX_PENDING; mem_rsp_ready = !fifo_full.
REQ-014 core_rsp_* SHALL present the FIFO head in arrival order, with first-word fall-through and no added cycle beyond the FIFO write: mem_rsp transfer at edge N gives core_rsp_valid after edge N.
REQ-015 Simultaneous FIFO push and pop SHALL be legal when full or empty-with-head; count unchanged.
REQ-016 busy SHALL equal (pending != 0) || mem_req_valid.
REQ-017 mem_rsp_valid while pending == 0 SHALL be flagged by a simulation-only assertion; the response is still enqueued if space exists.

Reset
REQ-018 When reset is low, the block SHALL immediately clear the request register, FIFO pointers and pending, regardless of clk.
REQ-019 Reset values SHALL be: mem_req_valid=0, core_rsp_valid=0, pending=0, busy=0, mem_rsp_ready=1.
REQ-020 core_req_ready SHALL be 0 while reset is low.
REQ-021 Reset asserted mid-transfer SHALL discard held requests and queued responses without emitting partial transfers.

Structure
REQ-022 Width macros (VX_DRAM_LINE_WIDTH, VX_DRAM_ADDR_WIDTH, VX_DRAM_TAG_WIDTH, VX_DRAM_BYTEEN_WIDTH) SHALL come from VX_define.vh and serve as parameter sources at instantiation; no local redefinition.
REQ-023 The response FIFO SHALL be one sub-module, VX_generic_queue (DATAW = DATA_WIDTH+TAG_WIDTH, SIZE = MAX_PENDING), with its reset adapted to active-low asynchronous.
REQ-024 The request register and credit counter SHALL live in this module.

Verification
REQ-025 After reset, 8 back-to-back reads with MAX_PENDING=8 and mem_req_ready=1 and no responses: all 8 accepted, pending=8, and core_req_ready=0 for a 9th read.
REQ-026 With pending=8, a write (rw=1, addr=0x100) SHALL still be accepted and appear on mem_req the next cycle with identical byteen, data and tag.
REQ-027 Responses with tags 3,1,2 and core_rsp_ready=1: core_rsp emits 3,1,2 in order, each one cycle after its mem_rsp transfer; pending drops by 3.
REQ-028 A core read accept coincides with a core_rsp transfer at pending=5: pending stays 5.
REQ-029 With mem_req_ready=0 for 4 cycles while holding addr 0x2A, mem_req_* stay stable, core_req_ready=0, and exactly one transfer occurs when ready rises.
REQ-030 Reset pulled low asynchronously with pending=4 and the FIFO holding 2 entries: outputs reach reset values before the next clk edge, and no stale response appears after release.
